// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_pkg
// Purpose : shared definitions for the CDB arbiter slice: default sizing,
//           the ALU tag type, the broadcast record carried on the CDB and a
//           helper that steps round-robin lane indices (lane 0 never used).
// Ports   : none (package).
// ---------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int CDB_NUM_FU = 8;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 8;

  typedef logic [CDB_TAG_W-1:0] alu_tag_t;

  // One broadcast as seen by the ROB and the reservation stations.
  typedef struct packed {
    logic                  valid;
    alu_tag_t              tag;
    logic [CDB_DATA_W-1:0] value;
    logic                  branch_fail;
  } cdb_t;

  // Lane that follows 'lane' in round-robin order; wraps past the top lane
  // back to 1 because tag 0 means "no ALU".
  function automatic int next_lane(input int lane, input int num_fu);
    return (lane >= num_fu - 1) ? 1 : lane + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
// Purpose : bundles the ALU-lane handshake and the CDB broadcast signals.
// Signals : fu_valid/fu_result/fu_branch_fail/fu_ready - per-lane handshake
//           flush      - ROB mispredict flush
//           cdb_stall  - consumers cannot take a broadcast
//           cdb_valid/cdb_tag/cdb_value/cdb_branch_fail - registered CDB
// Modports: slave  - the arbiter
//           master - the ALU lanes / consumers side
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int NUM_FU = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
);
  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU*DATA_W-1:0] fu_result;
  logic [NUM_FU-1:0]        fu_branch_fail;
  logic [NUM_FU-1:0]        fu_ready;
  logic                     flush;
  logic                     cdb_stall;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_value;
  logic                     cdb_branch_fail;

  modport slave (
    input  fu_valid, fu_result, fu_branch_fail, flush, cdb_stall,
    output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_branch_fail
  );

  modport master (
    output fu_valid, fu_result, fu_branch_fail, flush, cdb_stall,
    input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_branch_fail
  );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_rr_pick
// Purpose : combinational round-robin picker over lanes 1..NUM_FU-1.
// Ports   : req    in  pending lanes (lane 0 excluded)
//           rr_ptr in  lane granted last; search starts just after it
//           grant  out one-hot grant (all zero when nothing pending)
//           index  out granted lane index (0 when nothing pending)
// ---------------------------------------------------------------------------
module cdb_arbiter_rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 8,
  parameter int TAG_W  = 8
) (
  input  logic [NUM_FU-1:1] req,
  input  logic [TAG_W-1:0]  rr_ptr,
  output logic [NUM_FU-1:1] grant,
  output logic [TAG_W-1:0]  index
);

  int   lane;
  logic found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    lane  = next_lane(int'(rr_ptr), NUM_FU);
    for (int k = 1; k < NUM_FU; k++) begin
      if (!found && req[lane]) begin
        found       = 1'b1;
        grant[lane] = 1'b1;
        index       = TAG_W'(lane);
      end
      lane = next_lane(lane, NUM_FU);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Purpose : shares the single result broadcast bus among the ALU lanes.
//           Each lane owns a one-entry holding register; a round-robin
//           picker grants one pending lane per cycle into the registered CDB.
// Ports   : CLOCK_50 in  system clock, rising edge
//           RSTN_N   in  asynchronous active-low reset
//           bus      cdb_arbiter_if.slave (lane handshake, flush, stall, CDB)
// ---------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU,
  parameter int DATA_W = CDB_DATA_W,
  parameter int TAG_W  = CDB_TAG_W
) (
  input  logic          CLOCK_50,
  input  logic          RSTN_N,
  cdb_arbiter_if.slave  bus
);

  logic [NUM_FU-1:0]        hold_valid;
  logic [NUM_FU*DATA_W-1:0] hold_value;
  logic [NUM_FU-1:0]        hold_bf;
  logic [NUM_FU-1:0]        fu_ready_w;

  logic [NUM_FU-1:1]        pick_grant;
  logic [TAG_W-1:0]         pick_index;
  logic                     grant_en;
  logic [NUM_FU-1:0]        grant;
  logic                     grant_any;
  logic [DATA_W-1:0]        sel_value;
  logic                     sel_bf;

  logic [TAG_W-1:0]         rr_ptr_reg;
  logic                     cdb_valid_reg;
  logic [TAG_W-1:0]         cdb_tag_reg;
  logic [DATA_W-1:0]        cdb_value_reg;
  logic                     cdb_bf_reg;

  cdb_arbiter_rr_pick #(
    .NUM_FU (NUM_FU),
    .TAG_W  (TAG_W)
  ) u_pick (
    .req    (hold_valid[NUM_FU-1:1]),
    .rr_ptr (rr_ptr_reg),
    .grant  (pick_grant),
    .index  (pick_index)
  );

  // Grant depends only on registered state plus stall/flush, never on
  // fu_valid, so fu_ready carries no combinational path from fu_valid.
  assign grant_en  = !(bus.cdb_stall || bus.flush);
  assign grant     = grant_en ? {pick_grant, 1'b0} : '0;
  assign grant_any = |grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : gen_lane
      logic              valid_reg;
      logic [DATA_W-1:0] value_reg;
      logic              bf_reg;
      logic              take;

      // A full hold can still accept when it is being drained this cycle.
      assign fu_ready_w[gi] = (gi != 0) && !bus.flush &&
                              (!hold_valid[gi] || grant[gi]);
      assign take = bus.fu_valid[gi] && fu_ready_w[gi];

      always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
        if (!RSTN_N) begin
          valid_reg <= 1'b0;
          value_reg <= '0;
          bf_reg    <= 1'b0;
        end else if (bus.flush) begin
          valid_reg <= 1'b0;
        end else if (take) begin
          // Refill wins over the clear caused by a same-edge grant.
          valid_reg <= 1'b1;
          value_reg <= bus.fu_result[gi*DATA_W +: DATA_W];
          bf_reg    <= bus.fu_branch_fail[gi];
        end else if (grant[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign hold_valid[gi]                  = valid_reg;
      assign hold_value[gi*DATA_W +: DATA_W] = value_reg;
      assign hold_bf[gi]                     = bf_reg;
    end
  endgenerate

  // AND-OR select of the granted hold register.
  always_comb begin
    sel_value = '0;
    sel_bf    = 1'b0;
    for (int l = 0; l < NUM_FU; l++) begin
      if (grant[l]) begin
        sel_value = hold_value[l*DATA_W +: DATA_W];
        sel_bf    = hold_bf[l];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      rr_ptr_reg    <= '0;
      cdb_valid_reg <= 1'b0;
      cdb_tag_reg   <= '0;
      cdb_value_reg <= '0;
      cdb_bf_reg    <= 1'b0;
    end else begin
      if (grant_any) begin
        rr_ptr_reg <= pick_index;
      end
      if (bus.flush) begin
        cdb_valid_reg <= 1'b0;
      end else if (!bus.cdb_stall) begin
        if (grant_any) begin
          cdb_valid_reg <= 1'b1;
          cdb_tag_reg   <= pick_index;
          cdb_value_reg <= sel_value;
          cdb_bf_reg    <= sel_bf;
        end else begin
          // Idle cycle: only valid drops, payload fields keep their value.
          cdb_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign bus.fu_ready        = fu_ready_w;
  assign bus.cdb_valid       = cdb_valid_reg;
  assign bus.cdb_tag         = cdb_tag_reg;
  assign bus.cdb_value       = cdb_value_reg;
  assign bus.cdb_branch_fail = cdb_bf_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Purpose : scoreboard bench for cdb_arbiter. A driver applies directed and
//           random lane traffic and a pending-list reference model predicts
//           fu_ready and the broadcast sequence; a monitor checks every CDB
//           update against the expected-broadcast queue.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int TW = 8;

  logic CLOCK_50 = 1'b0;
  logic RSTN_N   = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  cdb_arbiter_if #(.NUM_FU(N), .DATA_W(DW), .TAG_W(TW)) bus ();

  cdb_arbiter #(.NUM_FU(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .CLOCK_50 (CLOCK_50),
    .RSTN_N   (RSTN_N),
    .bus      (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  cdb_t exp_q[$];

  // Reference model: which lanes hold a result, and the lane granted last.
  bit            m_valid[N];
  logic [DW-1:0] m_value[N];
  bit            m_bf[N];
  int            m_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int l = 0; l < N; l++) m_valid[l] = 0;
  endfunction

  // First pending lane after m_last in circular order over lanes 1..N-1.
  function automatic int model_pick();
    for (int k = 1; k < N; k++) begin
      int lane = ((m_last + k - 1) % (N - 1)) + 1;
      if (m_valid[lane]) return lane;
    end
    return 0;
  endfunction

  function automatic logic [N*DW-1:0] put(input logic [N*DW-1:0] base, input int l,
                                         input logic [DW-1:0] val);
    logic [N*DW-1:0] r = base;
    r[l*DW +: DW] = val;
    return r;
  endfunction

  // One clock cycle of stimulus plus the model's prediction for the next edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*DW-1:0] res,
                       input logic [N-1:0] bf, input bit fl, input bit st);
    int          g;
    logic [N-1:0] exp_rdy;
    cdb_t        e;
    @(negedge CLOCK_50);
    bus.fu_valid       = v;
    bus.fu_result      = res;
    bus.fu_branch_fail = bf;
    bus.flush          = fl;
    bus.cdb_stall      = st;
    #1;
    g = (fl || st) ? 0 : model_pick();
    for (int l = 0; l < N; l++)
      exp_rdy[l] = (l != 0) && !fl && (!m_valid[l] || g == l);
    check("fu_ready", 64'(bus.fu_ready), 64'(exp_rdy));
    if (g != 0) begin
      e.valid       = 1'b1;
      e.tag         = TW'(g);
      e.value       = m_value[g];
      e.branch_fail = m_bf[g];
      exp_q.push_back(e);
      m_last     = g;
      m_valid[g] = 0;
    end
    if (fl) model_clear();
    else begin
      for (int l = 1; l < N; l++) begin
        if (v[l] && exp_rdy[l]) begin
          m_valid[l] = 1;
          m_value[l] = res[l*DW +: DW];
          m_bf[l]    = bf[l];
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rand_cycle(input int dens, input int st_pct, input int fl_pct);
    logic [N-1:0]    v;
    logic [N-1:0]    bf;
    logic [N*DW-1:0] res;
    for (int l = 0; l < N; l++) begin
      v[l]  = ($urandom_range(0, 99) < dens);
      bf[l] = $urandom_range(0, 1) == 1;
      res   = put(res, l, $urandom);
    end
    cycle(v, res, bf, $urandom_range(0, 99) < fl_pct, $urandom_range(0, 99) < st_pct);
  endtask

  // Asynchronous reset applied between edges.
  task automatic do_reset();
    @(negedge CLOCK_50);
    #2;
    RSTN_N        = 1'b0;
    bus.fu_valid  = '0;
    bus.flush     = 1'b0;
    bus.cdb_stall = 1'b0;
    #1;
    check("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_fu_ready", 64'(bus.fu_ready), 64'hFE);
    exp_q.delete();
    model_clear();
    m_last = 0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RSTN_N = 1'b1;
  endtask

  // Monitor: classifies every edge and compares the registered CDB.
  initial begin
    cdb_t last, got, e;
    bit   st, fl, rs;
    last = '0;
    forever begin
      @(posedge CLOCK_50);
      st = bus.cdb_stall;
      fl = bus.flush;
      rs = RSTN_N;
      #1;
      got = {bus.cdb_valid, bus.cdb_tag, bus.cdb_value, bus.cdb_branch_fail};
      if (!rs || !RSTN_N) begin
        last = '0;
        check("cdb_reset", 64'(got), 64'd0);
      end else if (fl) begin
        e = last; e.valid = 1'b0;
        check("cdb_flush", 64'(got), 64'(e));
        last = e;
      end else if (st) begin
        check("cdb_stall_hold", 64'(got), 64'(last));
      end else if (got.valid) begin
        if (exp_q.size() == 0) begin
          e = last; e.valid = 1'b0;
          check("cdb_unexpected", 64'(got), 64'(e));
        end else begin
          e = exp_q.pop_front();
          check("cdb_broadcast", 64'(got), 64'(e));
        end
        last = e;
      end else begin
        e = last; e.valid = 1'b0;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("cdb_missing", 64'(got), 64'(e));
        end else begin
          check("cdb_idle", 64'(got), 64'(e));
        end
        last = e;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int dens[4]   = '{20, 50, 90, 70};
  int st_pct[4] = '{0, 25, 10, 40};
  int fl_pct[4] = '{0, 3, 5, 2};

  initial begin
    logic [N*DW-1:0] r;
    bus.fu_valid = '0; bus.fu_result = '0; bus.fu_branch_fail = '0;
    bus.flush = 1'b0; bus.cdb_stall = 1'b0;
    model_clear();
    m_last = 0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RSTN_N = 1'b1;

    // Mid-operation reset: holds 2 and 5 full, CDB showing lane 1.
    r = put(put(put('0, 1, 32'h11), 2, 32'h22), 5, 32'h55);
    cycle(8'b0010_0110, r, 8'b0000_0100, 1'b0, 1'b0);
    idle(1);
    do_reset();
    idle(3);

    // Single result from lane 3.
    cycle(8'b0000_1000, put('0, 3, 32'h15), '0, 1'b0, 1'b0);
    idle(3);

    // Lanes 1, 5, 7 together, then 1 and 7 pending after 7 wins (wrap).
    r = put(put(put('0, 1, 32'hA1), 5, 32'hA5), 7, 32'hA7);
    cycle(8'b1010_0010, r, 8'b1000_0000, 1'b0, 1'b0);
    idle(2);
    cycle(8'b1000_0010, put(put('0, 1, 32'hB1), 7, 32'hB7), 8'b0000_0010, 1'b0, 1'b0);
    idle(3);

    // Stall while CDB shows lane 2 / 0x40 and lane 4 pending.
    cycle(8'b0001_0100, put(put('0, 2, 32'h40), 4, 32'h44), '0, 1'b0, 1'b0);
    idle(1);
    repeat (3) cycle(8'b0001_0000, put('0, 4, 32'h99), '0, 1'b0, 1'b1);
    idle(3);

    // Flush together with a new lane-6 result while hold 1 is full.
    cycle(8'b0000_0010, put('0, 1, 32'hC1), '0, 1'b0, 1'b0);
    cycle(8'b0100_0000, put('0, 6, 32'hC6), '0, 1'b1, 1'b0);
    idle(3);

    // Lane 4 streaming values 1..10.
    for (int i = 1; i <= 10; i++) cycle(8'b0001_0000, put('0, 4, DW'(i)), '0, 1'b0, 1'b0);
    idle(3);

    // Randomized phases with occasional mid-run reset.
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        else rand_cycle(dens[p], st_pct[p], fl_pct[p]);
      end
    end
    idle(N + 2);

    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
